// File: rtl/dispensador_bebidas.sv
`default_nettype none
// ============================================================================
// Module      : dispensador_bebidas
// Description : Drink dispenser controller. Handles selection, coin payment with
//               cancel/timeout refund, size-scaled preparation, change delivery.
// Revision    : 1.0 - initial release
// ============================================================================
module dispensador_bebidas #(
    parameter int PRICE_W     = 16,
    parameter int COIN_W      = 12,
    parameter int TIMEOUT     = 16,
    parameter int PREP_CICLOS = 2,
    parameter int MAX_AZUCAR  = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sel_valid,
    input  logic [2:0]         sel_cafe,
    input  logic [1:0]         sel_tamano,
    input  logic [3:0]         sel_azucar,
    input  logic               coin_valid,
    input  logic [COIN_W-1:0]  coin_value,
    input  logic               cancel,
    output logic               busy,
    output logic [PRICE_W-1:0] precio,
    output logic [PRICE_W-1:0] credito,
    output logic               error_sel,
    output logic               salida_leche,
    output logic               salida_concentracion,
    output logic               salida_espuma,
    output logic [3:0]         salida_azucar,
    output logic               cambio_valid,
    output logic [PRICE_W-1:0] cambio,
    output logic               listo
);

    localparam int TIMER_W = $clog2(TIMEOUT) + 1;
    localparam int PREP_W  = $clog2(3 * PREP_CICLOS) + 1;
    localparam logic [TIMER_W-1:0] C_TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [3:0]         C_AZUCAR_MAX = 4'(MAX_AZUCAR);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PAGO       = 3'd1,
        S_PREPARA    = 3'd2,
        S_ENTREGA    = 3'd3,
        S_DEVOLUCION = 3'd4
    } state_t;

    state_t               r_state, w_state_n;
    logic [PRICE_W-1:0]   r_precio, w_precio_n;
    logic [PRICE_W-1:0]   r_credito, w_credito_n;
    logic [2:0]           r_cafe, w_cafe_n;
    logic [1:0]           r_tamano, w_tamano_n;
    logic [3:0]           r_azucar, w_azucar_n;
    logic [TIMER_W-1:0]   r_timer, w_timer_n;
    logic [PREP_W-1:0]    r_prep, w_prep_n;
    logic                 w_error_n;

    logic                 w_sel_ok;
    logic [3:0]           w_azucar_clamp;
    logic [PRICE_W:0]     w_sum;
    logic [PRICE_W-1:0]   w_credito_coin;
    logic [PREP_W-1:0]    w_prep_last;

    logic                 w_leche_n, w_conc_n, w_espuma_n, w_listo_n, w_cambio_valid_n;
    logic [3:0]           w_salida_azucar_n;
    logic [PRICE_W-1:0]   w_cambio_n;

    function automatic logic [PRICE_W-1:0] f_precio(input logic [2:0] cafe, input logic [1:0] tam);
        int p;
        case ({cafe, tam})
            {3'd1, 2'd1}: p = 500;
            {3'd1, 2'd2}: p = 1000;
            {3'd1, 2'd3}: p = 1500;
            {3'd2, 2'd1}: p = 750;
            {3'd2, 2'd2}: p = 1250;
            {3'd2, 2'd3}: p = 1750;
            {3'd3, 2'd1}: p = 1000;
            {3'd3, 2'd2}: p = 1500;
            {3'd3, 2'd3}: p = 2000;
            {3'd4, 2'd1}: p = 1250;
            {3'd4, 2'd2}: p = 1750;
            {3'd4, 2'd3}: p = 2500;
            default:      p = 0;
        endcase
        return PRICE_W'(p);
    endfunction

    assign w_sel_ok       = (sel_cafe >= 3'd1) && (sel_cafe <= 3'd4) && (sel_tamano != 2'd0);
    assign w_azucar_clamp = (sel_azucar > C_AZUCAR_MAX) ? C_AZUCAR_MAX : sel_azucar;
    assign w_sum          = {1'b0, r_credito} + (PRICE_W+1)'(coin_value);
    assign w_credito_coin = w_sum[PRICE_W] ? {PRICE_W{1'b1}} : w_sum[PRICE_W-1:0];
    assign w_prep_last    = PREP_W'(PREP_CICLOS * int'(r_tamano) - 1);

    always_comb begin
        w_state_n   = r_state;
        w_precio_n  = r_precio;
        w_credito_n = r_credito;
        w_cafe_n    = r_cafe;
        w_tamano_n  = r_tamano;
        w_azucar_n  = r_azucar;
        w_timer_n   = r_timer;
        w_prep_n    = r_prep;
        w_error_n   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sel_valid) begin
                    if (w_sel_ok) begin
                        w_state_n   = S_PAGO;
                        w_precio_n  = f_precio(sel_cafe, sel_tamano);
                        w_cafe_n    = sel_cafe;
                        w_tamano_n  = sel_tamano;
                        w_azucar_n  = w_azucar_clamp;
                        w_credito_n = '0;
                        w_timer_n   = '0;
                    end else begin
                        w_error_n = 1'b1;
                    end
                end
            end
            S_PAGO: begin
                if (coin_valid) w_credito_n = w_credito_coin;
                // cancel wins over payment, payment wins over timeout
                if (cancel) begin
                    w_state_n = S_DEVOLUCION;
                end else if (w_credito_n >= r_precio) begin
                    w_state_n = S_PREPARA;
                    w_prep_n  = '0;
                end else if (coin_valid) begin
                    w_timer_n = '0;
                end else if (r_timer == C_TIMER_LAST) begin
                    w_state_n = S_DEVOLUCION;
                end else begin
                    w_timer_n = r_timer + TIMER_W'(1);
                end
            end
            S_PREPARA: begin
                if (r_prep == w_prep_last) w_state_n = S_ENTREGA;
                else                       w_prep_n  = r_prep + PREP_W'(1);
            end
            S_ENTREGA, S_DEVOLUCION: begin
                w_state_n   = S_IDLE;
                w_precio_n  = '0;
                w_credito_n = '0;
                w_cafe_n    = '0;
                w_tamano_n  = '0;
                w_azucar_n  = '0;
                w_timer_n   = '0;
                w_prep_n    = '0;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they register in step with it
    always_comb begin
        w_leche_n         = 1'b0;
        w_conc_n          = 1'b0;
        w_espuma_n        = 1'b0;
        w_salida_azucar_n = '0;
        w_listo_n         = 1'b0;
        w_cambio_valid_n  = 1'b0;
        w_cambio_n        = '0;
        if (w_state_n == S_PREPARA) begin
            w_leche_n         = (w_cafe_n == 3'd2) || (w_cafe_n == 3'd4);
            w_conc_n          = (w_cafe_n == 3'd3) || (w_cafe_n == 3'd4);
            w_espuma_n        = (w_cafe_n == 3'd4);
            w_salida_azucar_n = w_azucar_n;
        end
        if (w_state_n == S_ENTREGA) begin
            w_listo_n = 1'b1;
            if (w_credito_n > w_precio_n) begin
                w_cambio_valid_n = 1'b1;
                w_cambio_n       = w_credito_n - w_precio_n;
            end
        end
        if (w_state_n == S_DEVOLUCION) begin
            w_cambio_valid_n = 1'b1;
            w_cambio_n       = w_credito_n;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state              <= S_IDLE;
            r_precio             <= '0;
            r_credito            <= '0;
            r_cafe               <= '0;
            r_tamano             <= '0;
            r_azucar             <= '0;
            r_timer              <= '0;
            r_prep               <= '0;
            busy                 <= 1'b0;
            error_sel            <= 1'b0;
            salida_leche         <= 1'b0;
            salida_concentracion <= 1'b0;
            salida_espuma        <= 1'b0;
            salida_azucar        <= '0;
            listo                <= 1'b0;
            cambio_valid         <= 1'b0;
            cambio               <= '0;
        end else begin
            r_state              <= w_state_n;
            r_precio             <= w_precio_n;
            r_credito            <= w_credito_n;
            r_cafe               <= w_cafe_n;
            r_tamano             <= w_tamano_n;
            r_azucar             <= w_azucar_n;
            r_timer              <= w_timer_n;
            r_prep               <= w_prep_n;
            busy                 <= (w_state_n != S_IDLE);
            error_sel            <= w_error_n;
            salida_leche         <= w_leche_n;
            salida_concentracion <= w_conc_n;
            salida_espuma        <= w_espuma_n;
            salida_azucar        <= w_salida_azucar_n;
            listo                <= w_listo_n;
            cambio_valid         <= w_cambio_valid_n;
            cambio               <= w_cambio_n;
        end
    end

    assign precio  = r_precio;
    assign credito = r_credito;

endmodule
`default_nettype wire

// File: tb/tb_dispensador_bebidas.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispensador_bebidas
// Description : Self-checking bench for dispensador_bebidas, order-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispensador_bebidas;

    localparam int PRICE_W     = 16;
    localparam int COIN_W      = 12;
    localparam int TIMEOUT     = 16;
    localparam int PREP_CICLOS = 2;
    localparam int MAX_AZUCAR  = 5;

    logic               clock = 1'b0;
    logic               reset;
    logic               sel_valid;
    logic [2:0]         sel_cafe;
    logic [1:0]         sel_tamano;
    logic [3:0]         sel_azucar;
    logic               coin_valid;
    logic [COIN_W-1:0]  coin_value;
    logic               cancel;
    logic               busy;
    logic [PRICE_W-1:0] precio;
    logic [PRICE_W-1:0] credito;
    logic               error_sel;
    logic               salida_leche;
    logic               salida_concentracion;
    logic               salida_espuma;
    logic [3:0]         salida_azucar;
    logic               cambio_valid;
    logic [PRICE_W-1:0] cambio;
    logic               listo;

    int total = 0;
    int bad   = 0;
    int plan_coin[$];
    bit plan_cancel[$];

    dispensador_bebidas #(
        .PRICE_W(PRICE_W), .COIN_W(COIN_W), .TIMEOUT(TIMEOUT),
        .PREP_CICLOS(PREP_CICLOS), .MAX_AZUCAR(MAX_AZUCAR)
    ) dut (
        .clock(clock), .reset(reset),
        .sel_valid(sel_valid), .sel_cafe(sel_cafe), .sel_tamano(sel_tamano), .sel_azucar(sel_azucar),
        .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel),
        .busy(busy), .precio(precio), .credito(credito), .error_sel(error_sel),
        .salida_leche(salida_leche), .salida_concentracion(salida_concentracion),
        .salida_espuma(salida_espuma), .salida_azucar(salida_azucar),
        .cambio_valid(cambio_valid), .cambio(cambio), .listo(listo)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Menu: base price per drink for a small cup, +500 per size step; large cappuccino is special
    function automatic int ref_price(input int cafe, input int tam);
        int base[4] = '{500, 750, 1000, 1250};
        int p;
        p = base[cafe-1] + 500 * (tam - 1);
        if (cafe == 4 && tam == 3) p = 2500;
        return p;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_precio"}, 32'(precio), 0);
        chk({tag, "_credito"}, 32'(credito), 0);
        chk({tag, "_cambio_valid"}, 32'(cambio_valid), 0);
        chk({tag, "_listo"}, 32'(listo), 0);
        chk({tag, "_azucar"}, 32'(salida_azucar), 0);
    endtask

    task automatic run_order(input int cafe, input int tam, input int az);
        int  price, credit, idle, outcome, coin, exp_az;
        bit  cn;
        sel_cafe   = 3'(cafe);
        sel_tamano = 2'(tam);
        sel_azucar = 4'(az);
        sel_valid  = 1'b1;
        step();
        sel_valid = 1'b0;
        if (!(cafe >= 1 && cafe <= 4 && tam >= 1 && tam <= 3)) begin
            chk("error_sel_pulse", 32'(error_sel), 1);
            chk("busy_after_bad_sel", 32'(busy), 0);
            step();
            chk("error_sel_drop", 32'(error_sel), 0);
            chk("busy_still_idle", 32'(busy), 0);
            return;
        end
        price = ref_price(cafe, tam);
        chk("error_sel_good", 32'(error_sel), 0);
        chk("busy_pago", 32'(busy), 1);
        chk("precio_latched", 32'(precio), price);
        chk("credito_start", 32'(credito), 0);

        credit  = 0;
        idle    = 0;
        outcome = 0;
        for (int i = 0; outcome == 0 && i < 200; i++) begin
            if (i < plan_coin.size()) begin
                coin = plan_coin[i];
                cn   = plan_cancel[i];
            end else begin
                coin = 0;
                cn   = 1'b0;
            end
            coin_valid = (coin != 0);
            coin_value = (coin != 0) ? COIN_W'(coin) : COIN_W'($urandom);
            cancel     = cn;
            sel_valid  = ($urandom_range(0, 3) == 0);
            sel_cafe   = 3'($urandom_range(1, 4));
            sel_tamano = 2'($urandom_range(1, 3));
            step();
            if (coin != 0) credit = (credit + coin > 65535) ? 65535 : credit + coin;
            if (cn) outcome = 2;
            else if (credit >= price) outcome = 1;
            else begin
                idle = (coin != 0) ? 0 : idle + 1;
                if (idle == TIMEOUT) outcome = 2;
            end
            if (outcome == 0) begin
                chk("credito_pago", 32'(credito), credit);
                chk("precio_hold", 32'(precio), price);
                chk("busy_hold", 32'(busy), 1);
                chk("cambio_valid_pago", 32'(cambio_valid), 0);
            end
        end
        coin_valid = 1'b0;
        cancel     = 1'b0;
        sel_valid  = 1'b0;

        exp_az = (az > MAX_AZUCAR) ? MAX_AZUCAR : az;
        if (outcome == 1) begin
            for (int k = 0; k < PREP_CICLOS * tam; k++) begin
                chk("prep_busy", 32'(busy), 1);
                chk("prep_leche", 32'(salida_leche), (cafe == 2 || cafe == 4) ? 1 : 0);
                chk("prep_conc", 32'(salida_concentracion), (cafe == 3 || cafe == 4) ? 1 : 0);
                chk("prep_espuma", 32'(salida_espuma), (cafe == 4) ? 1 : 0);
                chk("prep_azucar", 32'(salida_azucar), exp_az);
                chk("prep_listo", 32'(listo), 0);
                chk("prep_cambio_valid", 32'(cambio_valid), 0);
                step();
            end
            chk("entrega_listo", 32'(listo), 1);
            chk("entrega_cambio_valid", 32'(cambio_valid), (credit > price) ? 1 : 0);
            chk("entrega_cambio", 32'(cambio), (credit > price) ? credit - price : 0);
            chk("entrega_leche_off", 32'(salida_leche), 0);
            chk("entrega_conc_off", 32'(salida_concentracion), 0);
            chk("entrega_azucar_off", 32'(salida_azucar), 0);
        end else begin
            chk("devol_cambio_valid", 32'(cambio_valid), 1);
            chk("devol_cambio", 32'(cambio), credit);
            chk("devol_listo", 32'(listo), 0);
            chk("devol_leche", 32'(salida_leche), 0);
            chk("devol_azucar", 32'(salida_azucar), 0);
        end
        step();
        check_idle("after_order");
    endtask

    initial begin
        reset      = 1'b1;
        sel_valid  = 1'b0;
        sel_cafe   = '0;
        sel_tamano = '0;
        sel_azucar = '0;
        coin_valid = 1'b0;
        coin_value = '0;
        cancel     = 1'b0;
        step();
        step();
        check_idle("reset");
        chk("reset_error_sel", 32'(error_sel), 0);
        reset = 1'b0;
        step();
        check_idle("post_reset");

        // coins and cancel in IDLE have no effect
        coin_valid = 1'b1;
        coin_value = 12'd500;
        cancel     = 1'b1;
        step();
        coin_valid = 1'b0;
        cancel     = 1'b0;
        check_idle("idle_coin");

        // T1 negro pequeno, exact payment
        plan_coin = '{500};           plan_cancel = '{0};
        run_order(1, 1, 2);
        // T2 cappuccino grande, change 500
        plan_coin = '{1000, 1000, 1000}; plan_cancel = '{0, 0, 0};
        run_order(4, 3, 1);
        // T3 espresso mediano, timeout refund
        plan_coin = '{1000};          plan_cancel = '{0};
        run_order(3, 2, 0);
        // T4 leche mediano, cancel with coin in the same cycle
        plan_coin = '{1000};          plan_cancel = '{1};
        run_order(2, 2, 4);
        // T5 invalid selections and sugar clamp
        run_order(5, 2, 1);
        run_order(2, 0, 1);
        plan_coin = '{2000};          plan_cancel = '{0};
        run_order(3, 1, 9);
        // cancel with no credit still pulses a zero refund
        plan_coin = '{0};             plan_cancel = '{1};
        run_order(1, 2, 0);

        // T6 reset during PREPARA
        sel_cafe   = 3'd1;
        sel_tamano = 2'd3;
        sel_azucar = 4'd3;
        sel_valid  = 1'b1;
        step();
        sel_valid  = 1'b0;
        coin_valid = 1'b1;
        coin_value = 12'd1500;
        step();
        coin_valid = 1'b0;
        chk("t6_prep_azucar", 32'(salida_azucar), 3);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("t6_reset");
        step();
        check_idle("t6_after");

        // randomized orders
        for (int n = 0; n < 60; n++) begin
            int len;
            plan_coin   = {};
            plan_cancel = {};
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                int r;
                int coins[6] = '{50, 100, 200, 500, 1000, 2000};
                r = $urandom_range(0, 9);
                if (r < 3)      plan_coin.push_back(0);
                else if (r < 8) plan_coin.push_back(coins[$urandom_range(0, 5)]);
                else            plan_coin.push_back($urandom_range(1, 4095));
                plan_cancel.push_back($urandom_range(0, 19) == 0);
            end
            run_order($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 15));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
